// File: rtl/push_debounce.sv
// Two-channel push-button conditioner: synchronizer, debouncer and press-pulse generator for C and AC.
// Optional auto-repeat of the press pulse while a button is held, enabled by defining PUSH_AUTOREPEAT_EN.

module push_debounce_chan #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic hold,
  output logic push
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          settle;
  logic          rise;
  logic          fall;

  // NOTE: every flop here, synchronizer included, is cleared by the async reset so no
  // stale sample or partial count survives a reset pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make meta->sync a true two-stage shift.
      meta <= raw;
      sync <= meta;
    end
  end

  // A new level is accepted only after DB_CYCLES consecutive disagreeing samples;
  // the terminal compare keeps the counter from ever wrapping.
  assign settle = (sync != hold) && (cnt == DB_LAST);
  assign rise   = settle && !hold;
  assign fall   = settle && hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hold <= 1'b0;
    end else if (sync == hold) begin
      cnt <= '0;
    end else if (settle) begin
      cnt  <= '0;
      hold <= !hold;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef PUSH_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_fire;

  // Counts clocks since the last pulse; a falling hold wins over a coincident repeat.
  assign rpt_fire = hold && !fall && (rpt_cnt == RPT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
    end else if (!hold || fall || rpt_fire) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) push <= 1'b0;
    else        push <= rise || rpt_fire;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) push <= 1'b0;
    else        push <= rise;
  end
`endif

  if (DB_CYCLES < 2 || DB_CYCLES > (1 << 20)) begin : g_bad_db
    $error("push_debounce_chan: DB_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > (1 << 20)) begin : g_bad_rpt
    $error("push_debounce_chan: REPEAT_CYCLES out of range");
  end

endmodule

module push_debounce #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_c_raw,
  input  logic btn_ac_raw,
  output logic push_C,
  output logic push_AC,
  output logic hold_C,
  output logic hold_AC
);

  push_debounce_chan #(
    .DB_CYCLES     (DB_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_chan_c (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_c_raw),
    .hold  (hold_C),
    .push  (push_C)
  );

  push_debounce_chan #(
    .DB_CYCLES     (DB_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_chan_ac (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_ac_raw),
    .hold  (hold_AC),
    .push  (push_AC)
  );

endmodule

// File: tb/tb_push_debounce.sv
// Bench for push_debounce (DB_CYCLES=4, REPEAT_CYCLES=8): directed scenarios then random button
// activity, compared each cycle against a sliding-window reference model.

module tb_push_debounce;

  localparam int DB  = 4;
  localparam int RPT = 8;
`ifdef PUSH_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic btn_c_raw, btn_ac_raw;
  logic push_C, push_AC, hold_C, hold_AC;

  int n_tests = 0;
  int n_fail  = 0;

  push_debounce #(.DB_CYCLES(DB), .REPEAT_CYCLES(RPT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_c_raw  (btn_c_raw),
    .btn_ac_raw (btn_ac_raw),
    .push_C     (push_C),
    .push_AC    (push_AC),
    .hold_C     (hold_C),
    .hold_AC    (hold_AC)
  );

  always #5 clk = ~clk;

  // Reference model: every compared synchronized sample since reset is kept; a level
  // change is accepted when the last DB samples since the previous change all disagree.
  bit m_r1[2], m_r2[2], m_hold[2], m_push[2];
  bit hist0[$], hist1[$];
  int last_ev[2];
  int press_n[2];
  int edge_n;

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_r1[ch] = 0; m_r2[ch] = 0; m_hold[ch] = 0; m_push[ch] = 0;
      last_ev[ch] = 0; press_n[ch] = 0;
    end
    hist0.delete();
    hist1.delete();
    edge_n = 0;
  endfunction

  function automatic bit window_disagrees(int ch);
    bit h[$];
    int sz;
    h  = (ch == 0) ? hist0 : hist1;
    sz = h.size();
    if (sz - last_ev[ch] < DB) return 0;
    for (int i = sz - DB; i < sz; i++)
      if (h[i] == m_hold[ch]) return 0;
    return 1;
  endfunction

  function automatic void model_edge(bit rc, bit rac);
    bit raw[2];
    raw[0] = rc;
    raw[1] = rac;
    hist0.push_back(m_r2[0]);
    hist1.push_back(m_r2[1]);
    for (int ch = 0; ch < 2; ch++) begin
      m_push[ch] = 0;
      if (window_disagrees(ch)) begin
        m_hold[ch]  = !m_hold[ch];
        last_ev[ch] = (ch == 0) ? hist0.size() : hist1.size();
        if (m_hold[ch]) begin
          m_push[ch]  = 1;
          press_n[ch] = edge_n;
        end
      end else if (AUTO && m_hold[ch] && ((edge_n - press_n[ch]) % RPT == 0)) begin
        m_push[ch] = 1;
      end
      m_r2[ch] = m_r1[ch];
      m_r1[ch] = raw[ch];
    end
    edge_n++;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hold_C"},  hold_C,  m_hold[0]);
    check({tag, ".hold_AC"}, hold_AC, m_hold[1]);
    check({tag, ".push_C"},  push_C,  m_push[0]);
    check({tag, ".push_AC"}, push_AC, m_push[1]);
  endtask

  // Called #1 after an edge: drive, take the next edge, advance the model, compare.
  task automatic step(input string tag, input bit rc, input bit rac);
    btn_c_raw  = rc;
    btn_ac_raw = rac;
    @(posedge clk);
    model_edge(rc, rac);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_now");
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_all("in_rst");
    end
    rst_n = 1'b1;
  endtask

  int first_push;
  int pulses;
  bit rc, rac;

  initial begin
    btn_c_raw  = 1'b0;
    btn_ac_raw = 1'b0;
    rst_n      = 1'b1;
    #2;
    apply_reset(2);
    check("reset_hold_C_const", hold_C, 1'b0);
    check("reset_push_C_const", push_C, 1'b0);

    repeat (3) step("idle", 0, 0);

    // Single C press: pulse expected after the sixth edge of the hold (index 5).
    first_push = -1;
    for (int i = 0; i < 12; i++) begin
      step("c_press", 1, 0);
      if (push_C && first_push < 0) first_push = i;
    end
    check_int("c_press_latency", first_push, DB + 1);
    repeat (8) step("c_release", 0, 0);

    // AC glitch of 3 clocks, then a genuine AC press must still see full latency.
    repeat (3) step("ac_glitch", 0, 1);
    repeat (6) step("ac_glitch_after", 0, 0);
    first_push = -1;
    for (int i = 0; i < 10; i++) begin
      step("ac_press", 0, 1);
      if (push_AC && first_push < 0) first_push = i;
    end
    check_int("ac_press_latency", first_push, DB + 1);
    repeat (8) step("ac_release", 0, 0);

    // Simultaneous press and release on both channels.
    for (int i = 0; i < 10; i++) begin
      step("both_press", 1, 1);
      if (i == DB + 1) check("both_same_cycle", push_C & push_AC, 1'b1);
    end
    repeat (8) step("both_release", 0, 0);

    // Reset mid-count with C held, then re-debounce from zero.
    repeat (3) step("c_pre_rst", 1, 0);
    apply_reset(2);
    first_push = -1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step("c_post_rst", 1, 0);
      if (push_C) pulses++;
      if (push_C && first_push < 0) first_push = i;
    end
    check_int("post_rst_latency", first_push, DB + 1);
    check_int("post_rst_pulses", pulses, 1);
    repeat (8) step("c_post_rst_rel", 0, 0);

    // Long hold: press pulse plus repeats at +8, +16, +24 when auto-repeat is built in.
    pulses = 0;
    for (int i = 0; i < DB + 2 + 30; i++) begin
      step("c_long", 1, 0);
      if (push_C) pulses++;
    end
    check_int("long_hold_pulses", pulses, AUTO ? 4 : 1);
    repeat (8) step("c_long_rel", 0, 0);

    // Random activity with bursty toggling and occasional resets.
    rc  = 0;
    rac = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) rc  = !rc;
      if ($urandom_range(0, 5) == 0) rac = !rac;
      if ($urandom_range(0, 399) == 0) apply_reset($urandom_range(1, 3));
      else step("rand", rc, rac);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/push_debounce.md
PUSH_DEBOUNCE -- requirements
Module: push_debounce

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable synchronized samples required to accept a level change; legal range 2..2^20.
REQ-002 Parameter REPEAT_CYCLES, default 64: auto-repeat period in clocks; used only when PUSH_AUTOREPEAT_EN is defined; legal range 2..2^20.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 btn_c_raw  input  1  raw C push button, asynchronous to clk, active-high.
REQ-006 btn_ac_raw  input  1  raw AC push button, asynchronous to clk, active-high.
REQ-007 push_C  output  1  registered one-cycle press pulse for C; drives the push-button decoder's push_C input.
REQ-008 push_AC  output  1  registered one-cycle press pulse for AC; drives the push-button decoder's push_AC input.
REQ-009 hold_C  output  1  registered debounced level of C.
REQ-010 hold_AC  output  1  registered debounced level of AC.

Function
REQ-011 Each channel (C, AC) SHALL be an independent, identical copy of REQ-012..REQ-019; no shared state.
REQ-012 Raw input SHALL pass through a 2-flop synchronizer; only the second flop output (sync) is used downstream.
REQ-013 Debounce counter, width ceil(log2(DB_CYCLES)): sync == hold -> counter cleared to 0; sync != hold -> counter increments.
REQ-014 When sync != hold and counter == DB_CYCLES-1: hold toggles on that edge; counter clears to 0.
REQ-015 Any sample with sync == hold before the terminal count SHALL clear the counter; a glitch shorter than DB_CYCLES clocks produces no change on hold or pulse outputs.
REQ-016 Press pulse SHALL be high for exactly one clock, on the same edge hold rises 0->1; release (hold 1->0) produces no pulse.
REQ-017 Latency: raw change first sampled at edge k, then held stable -> hold and pulse change after edge k+1+DB_CYCLES.
REQ-018 Simultaneous qualifying presses on both channels SHALL assert push_C and push_AC in the same cycle (decoder then sees both).
REQ-019 Counter SHALL never wrap; the terminal compare bounds it at DB_CYCLES-1.

Reset
REQ-020 rst_n low SHALL immediately clear synchronizer flops, counters, repeat counters, hold_C, hold_AC, push_C, push_AC to 0, independent of clk.
REQ-021 Reset asserted mid-debounce SHALL discard the partial count; after release, a button still pressed is re-debounced from 0 and produces one press pulse.
REQ-022 No output SHALL pulse during reset or in the first clock after rst_n deasserts.

Configuration
REQ-023 Macro PUSH_AUTOREPEAT_EN defined: per channel, while hold == 1, a repeat counter counts clocks from the press pulse; every REPEAT_CYCLES clocks it emits one additional one-cycle pulse on that channel's push output and restarts; hold falling clears it.
REQ-024 PUSH_AUTOREPEAT_EN undefined: repeat counters and logic are absent; exactly one pulse per debounced press, regardless of hold duration.

Verification (DB_CYCLES=4, REPEAT_CYCLES=8)
REQ-025 btn_c_raw 0->1 before edge 0, held -> hold_C and push_C high after edge 5; push_C low after edge 6; push_AC stays 0.
REQ-026 btn_ac_raw high for 3 clocks then low -> hold_AC, push_AC never assert; counter returns to 0.
REQ-027 Both raw inputs rise before the same edge -> push_C and push_AC high in the same single cycle; on release, hold_C and hold_AC fall with no pulse.
REQ-028 rst_n pulsed low mid-count (after edge 2) with btn_c_raw held -> outputs 0 immediately; one push_C pulse DB_CYCLES+1 edges after the first post-reset sampling edge.
REQ-029 PUSH_AUTOREPEAT_EN defined, btn_c_raw held 30 clocks past press -> push_C pulses at press, press+8, press+16, press+24; undefined -> press pulse only.
